vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing and drives the pixel coordinate bus (row, col, vnotactive) consumed by the game display block. Samples the display's red/green/blue response, blanks it outside the active area, and drives the physical sync and colour pins, pipeline-aligned. Sits between the top level and the VGA connector, as the coordinate source for the pixel renderer.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_timing_gen_wrap_counter.sv | 41 ++++
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 tb/tb_vga_timing_gen.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 640x480@60 porch/sync/active
// values, total derivations and the sync pin polarity.
package vga_timing_pkg;

  localparam int unsigned DEF_CLK_DIV  = 32'd2;

  localparam int unsigned DEF_H_ACTIVE = 32'd640;
  localparam int unsigned DEF_H_FP     = 32'd16;
  localparam int unsigned DEF_H_SYNC   = 32'd96;
  localparam int unsigned DEF_H_BP     = 32'd48;

  localparam int unsigned DEF_V_ACTIVE = 32'd480;
  localparam int unsigned DEF_V_FP     = 32'd10;
  localparam int unsigned DEF_V_SYNC   = 32'd2;
  localparam int unsigned DEF_V_BP     = 32'd33;

  // Sync pins are asserted low on the connector.
  localparam logic SYNC_ACTIVE_LEVEL = 1'b0;

  // Full period of one axis: visible + front porch + sync + back porch.
  function automatic int unsigned calc_total(input int unsigned active_len,
                                             input int unsigned fp_len,
                                             input int unsigned sync_len,
                                             input int unsigned bp_len);
    return active_len + fp_len + sync_len + bp_len;
  endfunction

  localparam int unsigned DEF_H_TOTAL =
    calc_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL =
    calc_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-N counter with enable; carry is high on the enabled step that
// wraps the count back to zero, so it can chain into the next axis.
module wrap_counter #(
  parameter int unsigned MODULUS = 32'd800,
  parameter int unsigned W       = 32'd32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         carry
);

  logic [W-1:0] last_s;

  assign last_s = W'(MODULUS - 32'd1);

  // Carry marks the enabled step out of the last count value.
  always_comb begin
    carry = 1'b0;
    if (en && (count == last_s)) begin
      carry = 1'b1;
    end else begin
      carry = 1'b0;
    end
  end

  // Count register: clears on reset, steps on enable, wraps on carry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (en) begin
      if (carry) begin
        count <= '0;
      end else begin
        count <= count + W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel divider, horizontal/vertical counters,
// and a two-stage pipeline that lines blanking and sync up with the colour
// the display block returns one CLK after the coordinates change.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] row,
  output logic [31:0] col,
  output logic        vnotactive,
  output logic        frame_start,
  input  logic        red,
  input  logic        green,
  input  logic        blue,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b
);

  localparam int unsigned H_TOTAL   = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL   = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END    = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END    = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [2:0]  DIV_LAST  = 3'(CLK_DIV - 32'd1);

  logic [2:0] div_r;
  logic       tick_s;
  logic       h_carry_s;
  logic       v_carry_s;
  logic       active_s;
  logic       hs_raw_s;
  logic       vs_raw_s;
  logic       active_d1_r;
  logic       hs_d1_r;
  logic       vs_d1_r;

  assign tick_s = (div_r == DIV_LAST);

  // Pixel divider: counts 0..CLK_DIV-1, tick on the last count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_r <= 3'd0;
    end else if (tick_s) begin
      div_r <= 3'd0;
    end else begin
      div_r <= div_r + 3'd1;
    end
  end

  wrap_counter #(.MODULUS(H_TOTAL), .W(32'd32)) u_hcnt (
    .CLK   (CLK),
    .RST   (RST),
    .en    (tick_s),
    .count (col),
    .carry (h_carry_s)
  );

  wrap_counter #(.MODULUS(V_TOTAL), .W(32'd32)) u_vcnt (
    .CLK   (CLK),
    .RST   (RST),
    .en    (h_carry_s),
    .count (row),
    .carry (v_carry_s)
  );

  // Raster decode from the live counters; vnotactive is unpipelined so the
  // display sees blanking in the same cycle the row changes.
  always_comb begin
    vnotactive = (row >= V_ACTIVE);
    active_s   = (col < H_ACTIVE) && (row < V_ACTIVE);
    hs_raw_s   = (col >= HS_START) && (col < HS_END);
    vs_raw_s   = (row >= VS_START) && (row < VS_END);
  end

  // Frame marker: high only on the cycle the counters land on (0,0).
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= v_carry_s;
    end
  end

  // Stage 1: hold decode for one CLK while the display computes colour.
  always_ff @(posedge CLK) begin
    if (RST) begin
      active_d1_r <= 1'b0;
      hs_d1_r     <= 1'b0;
      vs_d1_r     <= 1'b0;
    end else begin
      active_d1_r <= active_s;
      hs_d1_r     <= hs_raw_s;
      vs_d1_r     <= vs_raw_s;
    end
  end

  // Stage 2: drive pins; colour is blanked outside the visible area.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vga_hs <= ~SYNC_ACTIVE_LEVEL;
      vga_vs <= ~SYNC_ACTIVE_LEVEL;
      vga_r  <= 1'b0;
      vga_g  <= 1'b0;
      vga_b  <= 1'b0;
    end else begin
      vga_hs <= hs_d1_r ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
      vga_vs <= vs_d1_r ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
      if (active_d1_r) begin
        vga_r <= red;
        vga_g <= green;
        vga_b <= blue;
      end else begin
        vga_r <= 1'b0;
        vga_g <= 1'b0;
        vga_b <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three instances (default geometry at CLK_DIV=2, and two
// shrunken geometries at CLK_DIV=2 and 1) share clock, reset and colour.
// Expected outputs come from closed-form arithmetic on the number of clocks
// since reset release.
module tb_vga_timing_gen;

  typedef struct packed {
    int unsigned d;
    int unsigned ha, hf, hs, hb;
    int unsigned va, vf, vs, vb;
  } cfg_t;

  typedef struct packed {
    logic [31:0] row;
    logic [31:0] col;
    logic        vna;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [2:0]  rgb;
  } exp_t;

  localparam cfg_t CA = '{d:2, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33};
  localparam cfg_t CB = '{d:2, ha:8,   hf:2,  hs:3,  hb:2,  va:6,   vf:2,  vs:2, vb:2};
  localparam cfg_t CC = '{d:1, ha:10,  hf:3,  hs:4,  hb:3,  va:5,   vf:1,  vs:2, vb:1};
  localparam int NCYC = 6000;

  logic CLK = 1'b0;
  logic RST, red, green, blue;

  logic [31:0] row_a, col_a, row_b, col_b, row_c, col_c;
  logic vna_a, fs_a, hs_a, vs_a, r_a, g_a, b_a;
  logic vna_b, fs_b, hs_b, vs_b, r_b, g_b, b_b;
  logic vna_c, fs_c, hs_c, vs_c, r_c, g_c, b_c;

  int total = 0;
  int bad   = 0;
  exp_t qa[$], qb[$], qc[$];

  always #5 CLK = ~CLK;

  vga_timing_gen dut_a (
    .CLK(CLK), .RST(RST), .row(row_a), .col(col_a), .vnotactive(vna_a),
    .frame_start(fs_a), .red(red), .green(green), .blue(blue),
    .vga_hs(hs_a), .vga_vs(vs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
  );

  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_b (
    .CLK(CLK), .RST(RST), .row(row_b), .col(col_b), .vnotactive(vna_b),
    .frame_start(fs_b), .red(red), .green(green), .blue(blue),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
  );

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(10), .H_FP(3), .H_SYNC(4), .H_BP(3),
                   .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_c (
    .CLK(CLK), .RST(RST), .row(row_c), .col(col_c), .vnotactive(vna_c),
    .frame_start(fs_c), .red(red), .green(green), .blue(blue),
    .vga_hs(hs_c), .vga_vs(vs_c), .vga_r(r_c), .vga_g(g_c), .vga_b(b_c)
  );

  // Reference: k = clocks since reset release; pixel index = k / CLK_DIV.
  // Pins show the raster position of two clocks earlier; colour is whatever
  // the display drove in the clock just before the pins update.
  function automatic exp_t model(input cfg_t c, input int unsigned k,
                                 input logic [2:0] rgb);
    exp_t m;
    int unsigned ht, vt, p, pj, cj, rj;
    logic act;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    p = k / c.d;
    m.col = p % ht;
    m.row = (p / ht) % vt;
    m.vna = (m.row >= c.va);
    m.fs  = (k > 0) && ((k % c.d) == 0) && ((p % (ht * vt)) == 0);
    if (k >= 2) begin
      pj = (k - 2) / c.d;
      cj = pj % ht;
      rj = (pj / ht) % vt;
      act = (cj < c.ha) && (rj < c.va);
      m.hs = !((cj >= c.ha + c.hf) && (cj < c.ha + c.hf + c.hs));
      m.vs = !((rj >= c.va + c.vf) && (rj < c.va + c.vf + c.vs));
      m.rgb = act ? rgb : 3'b000;
    end else begin
      m.hs = 1'b1;
      m.vs = 1'b1;
      m.rgb = 3'b000;
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [31:0] row,
                     input logic [31:0] col, input logic vna, input logic fs,
                     input logic hs, input logic vs, input logic [2:0] rgb);
    chk({tag, ".row"}, row, e.row);
    chk({tag, ".col"}, col, e.col);
    chk({tag, ".vnotactive"}, {31'd0, vna}, {31'd0, e.vna});
    chk({tag, ".frame_start"}, {31'd0, fs}, {31'd0, e.fs});
    chk({tag, ".vga_hs"}, {31'd0, hs}, {31'd0, e.hs});
    chk({tag, ".vga_vs"}, {31'd0, vs}, {31'd0, e.vs});
    chk({tag, ".vga_rgb"}, {29'd0, rgb}, {29'd0, e.rgb});
  endtask

  // Monitor: after each active edge, pop one expectation per instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        cmp("a", e, row_a, col_a, vna_a, fs_a, hs_a, vs_a, {r_a, g_a, b_a});
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        cmp("b", e, row_b, col_b, vna_b, fs_b, hs_b, vs_b, {r_b, g_b, b_b});
      end
      if (qc.size() > 0) begin
        e = qc.pop_front();
        cmp("c", e, row_c, col_c, vna_c, fs_c, hs_c, vs_c, {r_c, g_c, b_c});
      end
    end
  end

  // Stimulus: random colour every clock; long reset-free run first, then
  // random plus one fixed mid-frame reset.
  initial begin
    int unsigned k;
    logic [2:0] rgb;
    logic rst_now;
    RST = 1'b1;
    red = 1'b0;
    green = 1'b0;
    blue = 1'b0;
    k = 0;
    for (int n = 0; n < NCYC; n++) begin
      @(negedge CLK);
      rst_now = (n < 3) || (n == 4000) ||
                ((n >= 3400) && ($urandom_range(0, 199) == 0));
      rgb = 3'($urandom_range(0, 7));
      RST = rst_now;
      {red, green, blue} = rgb;
      k = rst_now ? 0 : k + 1;
      qa.push_back(model(CA, k, rgb));
      qb.push_back(model(CB, k, rgb));
      qc.push_back(model(CC, k, rgb));
    end
    @(negedge CLK);
    @(negedge CLK);
    total++;
    if ((qa.size() + qb.size() + qc.size()) != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", qa.size() + qb.size() + qc.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
